// File: rtl/control_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for the integer datapath.
// Decodes R/I/load/store (plus M multiply) and traps anything else to ILLEGAL.
module control_fsm #(
  parameter int pcmux_N     = 2,
  parameter int ifuresctl_N = 2,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     func3,
  input  logic [1:0]                     func7b50,
  input  logic                           exdone,
  output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
  output logic                           pcnextctl,
  output logic                           instrre,
  output logic                           regwe,
  output logic                           regre,
  output logic                           bmuxctl,
  output logic [3:0]                     aluctl,
  output logic                           mulstart,
  output logic [1:0]                     mulctl,
  output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
  output logic                           dmemwe,
  output logic [2:0]                     dmctl,
  output logic                           regwctl,
  output logic                           illegal,
  output logic                           retired
);

  localparam int IW = $clog2(ifuresctl_N);
  localparam int CW = $clog2(MUL_TIMEOUT + 1);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, ILLEGAL
  } state_t;

  state_t        state;
  logic [6:0]    op;
  logic [2:0]    f3;
  logic [1:0]    f7;
  logic [CW-1:0] cnt;

  logic is_r, is_i, is_ld, is_st, is_mul, is_mem;
  logic legal;
  logic [3:0] alu_op;

  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_ld  = (op == OP_L);
  assign is_st  = (op == OP_S);
  assign is_mem = is_ld | is_st;
  assign is_mul = is_r & (f7 == 2'b01);

  // Legality is judged on the live instruction fields during DECODE
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      opcode == OP_R:
        legal = (func7b50 == 2'b00) | (func7b50 == 2'b10) |
                ((func7b50 == 2'b01) & ~func3[2]);
      opcode == OP_I:
        legal = 1'b1;
      opcode == OP_L:
        legal = (func3 inside {3'b000, 3'b001, 3'b010,
                               3'b100, 3'b101});
      opcode == OP_S:
        legal = (func3 inside {3'b000, 3'b001, 3'b010});
      default:
        legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = 4'd0;
    unique case (f3)
      3'b000: alu_op = (is_r & (f7 == 2'b10)) ? 4'd1 : 4'd0;
      3'b001: alu_op = 4'd2;
      3'b010: alu_op = 4'd3;
      3'b011: alu_op = 4'd4;
      3'b100: alu_op = 4'd5;
      3'b101: alu_op = f7[1] ? 4'd7 : 4'd6;
      3'b110: alu_op = 4'd8;
      3'b111: alu_op = 4'd9;
      default: alu_op = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op    <= '0;
      f3    <= '0;
      f7    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          op    <= opcode;
          f3    <= func3;
          f7    <= func7b50;
          cnt   <= '0;
          state <= legal ? EXEC : ILLEGAL;
        end
        EXEC: begin
          if (is_mul) begin
            if (exdone) begin
              state <= WB;
              cnt   <= '0;
            end else if (cnt == CW'(MUL_TIMEOUT - 1)) begin
              state <= ILLEGAL;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            state <= is_mem ? MEM : WB;
          end
        end
        MEM:     state <= is_st ? FETCH : WB;
        WB:      state <= FETCH;
        ILLEGAL: state <= ILLEGAL;
        default: state <= ILLEGAL;
      endcase
    end
  end

  // Moore decode; everything forced low while reset is asserted
  always_comb begin
    pcmuxctl  = '0;
    pcnextctl = 1'b0;
    instrre   = 1'b0;
    regwe     = 1'b0;
    regre     = 1'b0;
    bmuxctl   = 1'b0;
    aluctl    = 4'd0;
    mulstart  = 1'b0;
    mulctl    = 2'd0;
    ifuresctl = '0;
    dmemwe    = 1'b0;
    dmctl     = 3'd0;
    regwctl   = 1'b0;
    illegal   = 1'b0;
    retired   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:  instrre = 1'b1;
        DECODE: regre   = 1'b1;
        EXEC: begin
          bmuxctl = is_mem ? 1'b0 : op[5];
          aluctl  = is_mem ? 4'd0 : alu_op;
          if (is_mul) begin
            ifuresctl = IW'(1);
            mulctl    = f3[1:0];
            mulstart  = (cnt == '0);
          end
        end
        MEM: begin
          dmctl = f3;
          if (is_st) begin
            dmemwe    = 1'b1;
            pcnextctl = 1'b1;
            retired   = 1'b1;
          end
        end
        WB: begin
          regwe     = 1'b1;
          pcnextctl = 1'b1;
          retired   = 1'b1;
          regwctl   = is_ld;
          ifuresctl = is_mul ? IW'(1) : '0;
          aluctl    = is_ld ? 4'd0 : alu_op;
          dmctl     = is_ld ? f3 : 3'd0;
        end
        ILLEGAL: illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction expected output
// sequences built from the ISA rules, checked every cycle.
module tb_control_fsm;

  localparam int MUL_TO = 64;
  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] L = 7'b0000011;
  localparam logic [6:0] S = 7'b0100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [1:0] func7b50 = '0;
  logic exdone = 1'b0;

  logic [0:0] pcmuxctl;
  logic pcnextctl, instrre, regwe, regre, bmuxctl;
  logic [3:0] aluctl;
  logic mulstart;
  logic [1:0] mulctl;
  logic [0:0] ifuresctl;
  logic dmemwe;
  logic [2:0] dmctl;
  logic regwctl, illegal, retired;

  control_fsm #(.pcmux_N(2), .ifuresctl_N(2), .MUL_TIMEOUT(MUL_TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
    .func7b50(func7b50), .exdone(exdone),
    .pcmuxctl(pcmuxctl), .pcnextctl(pcnextctl), .instrre(instrre),
    .regwe(regwe), .regre(regre), .bmuxctl(bmuxctl), .aluctl(aluctl),
    .mulstart(mulstart), .mulctl(mulctl), .ifuresctl(ifuresctl),
    .dmemwe(dmemwe), .dmctl(dmctl), .regwctl(regwctl),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcmux;
    logic       pcnextctl;
    logic       instrre;
    logic       regwe;
    logic       regre;
    logic       bmuxctl;
    logic [3:0] aluctl;
    logic       mulstart;
    logic [1:0] mulctl;
    logic       ifuresctl;
    logic       dmemwe;
    logic [2:0] dmctl;
    logic       regwctl;
    logic       illegal;
    logic       retired;
  } out_t;

  out_t got, exp_e;
  out_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int cyc_n = 0, last_fetch = 0, lat = 0;
  int n_ms = 0, n_rw = 0, n_dw = 0;
  logic [3:0] wb_alu = '0;
  logic [2:0] wb_dm = '0;
  logic wb_rwc = 1'b0;

  assign got = {pcmuxctl, pcnextctl, instrre, regwe, regre, bmuxctl,
                aluctl, mulstart, mulctl, ifuresctl, dmemwe, dmctl,
                regwctl, illegal, retired};

  always @(negedge clk) begin
    cyc_n++;
    if (instrre) last_fetch = cyc_n;
    if (retired) lat = cyc_n - last_fetch + 1;
    if (mulstart) n_ms++;
    if (dmemwe) n_dw++;
    if (regwe) begin
      n_rw++;
      wb_alu = aluctl;
      wb_dm = dmctl;
      wb_rwc = regwctl;
    end
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      n_vec++;
      if (got !== exp_e) begin
        n_err++;
        $display("FAIL cycle %0d outputs: got %h required %h",
                 cyc_n, got, exp_e);
      end
    end
  end

  function automatic logic [3:0] alu_model(input logic [6:0] op,
      input logic [2:0] f3, input logic [1:0] f7);
    logic [3:0] a;
    case (f3)
      3'd0: a = (op == R && f7 == 2'b10) ? 4'd1 : 4'd0;
      3'd1: a = 4'd2;
      3'd2: a = 4'd3;
      3'd3: a = 4'd4;
      3'd4: a = 4'd5;
      3'd5: a = f7[1] ? 4'd7 : 4'd6;
      3'd6: a = 4'd8;
      default: a = 4'd9;
    endcase
    return a;
  endfunction

  function automatic logic legal_model(input logic [6:0] op,
      input logic [2:0] f3, input logic [1:0] f7);
    if (op == R) return f7 == 2'b00 || f7 == 2'b10 ||
                        (f7 == 2'b01 && f3 < 3'd4);
    if (op == I) return 1'b1;
    if (op == L) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (op == S) return f3 inside {3'd0, 3'd1, 3'd2};
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input int a, input int b);
    n_vec++;
    if (a !== b) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, a, b);
    end
  endtask

  task automatic cyc(input out_t e, input logic xd, input logic r);
    @(posedge clk);
    #1;
    rst = r;
    exdone = xd;
    exp_q.push_back(e);
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) cyc('0, 1'b0, 1'b1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    n_ms = 0; n_rw = 0; n_dw = 0; lat = 0;
  endtask

  task automatic front(input logic [6:0] op, input logic [2:0] f3,
                       input logic [1:0] f7);
    out_t e;
    opcode = op; func3 = f3; func7b50 = f7;
    e = '0; e.instrre = 1'b1; cyc(e, 1'b0, 1'b0);
    e = '0; e.regre = 1'b1;   cyc(e, 1'b0, 1'b0);
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                       input logic [1:0] f7, input int k);
    out_t e;
    logic [3:0] a;
    a = alu_model(op, f3, f7);
    front(op, f3, f7);
    if (!legal_model(op, f3, f7)) begin
      e = '0; e.illegal = 1'b1;
      repeat (4) cyc(e, 1'b0, 1'b0);
      return;
    end
    if (op == R && f7 == 2'b01) begin
      for (int i = 1; i <= MUL_TO; i++) begin
        e = '0; e.bmuxctl = 1'b1; e.aluctl = a; e.ifuresctl = 1'b1;
        e.mulctl = f3[1:0]; e.mulstart = (i == 1);
        cyc(e, (i == k), 1'b0);
        if (i == k) break;
      end
      if (k == 0) begin
        e = '0; e.illegal = 1'b1;
        repeat (4) cyc(e, 1'b0, 1'b0);
        return;
      end
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.retired = 1'b1;
      e.ifuresctl = 1'b1; e.aluctl = a;
      cyc(e, 1'b0, 1'b0);
    end else if (op == L || op == S) begin
      cyc('0, 1'b0, 1'b0);
      e = '0; e.dmctl = f3;
      if (op == S) begin
        e.dmemwe = 1'b1; e.pcnextctl = 1'b1; e.retired = 1'b1;
      end
      cyc(e, 1'b0, 1'b0);
      if (op == L) begin
        e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.retired = 1'b1;
        e.regwctl = 1'b1; e.dmctl = f3;
        cyc(e, 1'b0, 1'b0);
      end
    end else begin
      e = '0; e.bmuxctl = (op == R); e.aluctl = a;
      cyc(e, 1'b0, 1'b0);
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.retired = 1'b1;
      e.aluctl = a;
      cyc(e, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_cycles(2);

    instr(R, 3'd0, 2'b00, 0); settle();
    chk("add_lat", lat, 4); chk("add_alu", wb_alu, 0); clr();
    instr(R, 3'd0, 2'b10, 0); settle();
    chk("sub_alu", wb_alu, 1); clr();
    instr(I, 3'd5, 2'b10, 0); settle();
    chk("srai_alu", wb_alu, 7); chk("srai_lat", lat, 4); clr();
    instr(I, 3'd0, 2'b10, 0); settle();
    chk("addi_nosub", wb_alu, 0); clr();
    instr(R, 3'd5, 2'b00, 0); settle();
    chk("srl_alu", wb_alu, 6); clr();
    instr(R, 3'd3, 2'b00, 0); settle(); clr();
    instr(I, 3'd7, 2'b00, 0); settle(); clr();

    instr(R, 3'd0, 2'b01, 5); settle();
    chk("mul_lat", lat, 8); chk("mul_starts", n_ms, 1);
    chk("mul_regwe", n_rw, 1); clr();
    instr(R, 3'd1, 2'b01, 1); settle();
    chk("mulh_fast_lat", lat, 4); clr();

    instr(L, 3'd2, 2'b00, 0); settle();
    chk("lw_lat", lat, 5); chk("lw_dmctl", wb_dm, 2);
    chk("lw_regwctl", wb_rwc, 1); clr();
    instr(L, 3'd4, 2'b00, 0); settle(); clr();
    instr(S, 3'd0, 2'b00, 0); settle();
    chk("sb_lat", lat, 4); chk("sb_dmemwe", n_dw, 1);
    chk("sb_regwe", n_rw, 0); clr();
    instr(S, 3'd2, 2'b00, 0); settle(); clr();

    instr(7'b1101111, 3'd0, 2'b00, 0); settle();
    chk("jal_illegal", illegal, 1); clr();
    rst_cycles(1);
    instr(R, 3'd4, 2'b01, 0); settle();
    chk("div_illegal", illegal, 1); chk("div_regwe", n_rw, 0); clr();
    rst_cycles(1);
    instr(L, 3'd3, 2'b00, 0); rst_cycles(1);
    instr(S, 3'd4, 2'b00, 0); rst_cycles(1);
    instr(R, 3'd0, 2'b11, 0); rst_cycles(1);

    instr(R, 3'd0, 2'b01, 0); settle();
    chk("mul_timeout", illegal, 1); chk("to_starts", n_ms, 1); clr();
    rst_cycles(1);

    front(L, 3'd2, 2'b00); cyc('0, 1'b0, 1'b0); rst_cycles(1);
    front(S, 3'd0, 2'b00); cyc('0, 1'b0, 1'b0); rst_cycles(1);
    settle();
    chk("abort_regwe", n_rw, 0); chk("abort_dmemwe", n_dw, 0); clr();
    instr(R, 3'd6, 2'b00, 0); settle();
    chk("post_abort_lat", lat, 4); chk("or_alu", wb_alu, 8); clr();

    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
